vfd_word_collector: RTL and testbench
=====================================

VFD_WORD_COLLECTOR -- requirements
Module: vfd_word_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning bits per word (legal range 2..7).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_bit  input  1  serial data bit.
REQ-005 SHALL have port i_bit_valid  input  1  i_bit is sampled on this clock edge.
REQ-006 SHALL have port o_word  output  WIDTH  head word of the output buffer.
REQ-007 SHALL have port o_word_valid  output  1  o_word holds a completed word.
REQ-008 SHALL have port i_word_ready  input  1  consumer accepts o_word on this edge.
REQ-009 SHALL have port o_bit_count  output  3  bits collected toward the current word (0..WIDTH-1).
REQ-010 SHALL have port o_overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-011 SHALL shift each valid bit into an internal assembly register at the MSB, shifting existing bits toward the LSB ({i_bit, asm[WIDTH-1:1]}), so the first bit received lands at bit 0.
REQ-012 SHALL ignore i_bit and hold all assembly state when i_bit_valid is low.
REQ-013 SHALL run a two-state FSM: IDLE (count 0) and FILL (count 1..WIDTH-1); IDLE->FILL on a valid bit; FILL->FILL on a valid bit while count < WIDTH-1; FILL->IDLE on the valid bit that completes the word.
REQ-014 SHALL, on the completing bit, push {i_bit, asm[WIDTH-1:1]} into a 2-entry FIFO and return o_bit_count to 0 on the same edge.
REQ-015 SHALL present a pushed word on o_word with o_word_valid high one cycle after the completing edge if the FIFO was empty; latency is exactly 1 cycle.
REQ-016 SHALL pop the head entry on an edge where o_word_valid and i_word_ready are both high; o_word and o_word_valid SHALL be stable otherwise.
REQ-017 SHALL accept a push when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-018 SHALL, on a push into a full FIFO without a simultaneous pop, drop the new word, leave FIFO contents unchanged, and set o_overflow; the assembly counter still returns to 0.
REQ-019 SHALL keep o_overflow high until reset.
REQ-020 SHALL preserve FIFO order (oldest word first); the pointers wrap modulo 2.
REQ-021 SHALL drive o_word to 0 while o_word_valid is low.

Reset
REQ-022 SHALL, while rst is high, immediately force: FSM IDLE, assembly register 0, o_bit_count 0, FIFO empty, o_word 0, o_word_valid 0, o_overflow 0.
REQ-023 SHALL discard any partially assembled word and all buffered words when reset asserts mid-operation.
REQ-024 SHALL sample the first bit on the first rising clk edge after rst deasserts.

Configuration
REQ-025 SHALL, when macro VFD_COLLECTOR_PARITY_EN is defined, add output port o_word_parity (1 bit), equal to the XOR of all bits of o_word, stored with each FIFO entry, and 0 in reset or when o_word_valid is low.
REQ-026 SHALL, when VFD_COLLECTOR_PARITY_EN is undefined, omit o_word_parity and its storage entirely; all other behaviour is identical.

Verification
REQ-027 SHALL cover: WIDTH=5, i_word_ready=1, bits 1,0,1,1,0 on consecutive cycles -> o_word=5'b01101 with o_word_valid=1 for exactly one cycle, starting one cycle after the 5th bit; o_word_parity=1 when parity is enabled.
REQ-028 SHALL cover: same bits with idle cycles (i_bit_valid=0) interleaved -> identical word, o_bit_count steps 0,1,2,3,4,0 only on valid cycles.
REQ-029 SHALL cover: i_word_ready=0, three words 5'b00001, 5'b00010, 5'b00100 -> first two buffered, third dropped, o_overflow=1; then ready=1 pops 00001 then 00010 and o_word_valid falls.
REQ-030 SHALL cover: FIFO full, pop and completing bit on the same edge -> no overflow, new word queued behind the remaining entry.
REQ-031 SHALL cover: reset asserted asynchronously mid-clock after 3 bits, with 1 word buffered -> all outputs 0 immediately; the next 5 bits form a fresh word.

Source files
------------

// File: rtl/vfd_word_collector.sv
// Serial-to-parallel word collector with a 2-entry output FIFO.
// Latency: a completed word appears on o_word one cycle after its last bit (FIFO empty).
// Backpressure: i_word_ready pops the FIFO; a word completed into a full FIFO is dropped and o_overflow sticks high.
//
// Ports:
//   clk, rst             single clock, asynchronous active-high reset
//   i_bit, i_bit_valid   serial data bit, sampled when i_bit_valid is high (first bit -> word bit 0)
//   o_word, o_word_valid head of the output FIFO (o_word is 0 while not valid)
//   i_word_ready         consumer accepts o_word on this edge
//   o_bit_count          bits collected toward the current word (0..WIDTH-1)
//   o_overflow           sticky: a completed word was dropped
//   o_word_parity        XOR of o_word bits, only when VFD_COLLECTOR_PARITY_EN is defined
module vfd_word_collector #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_bit,
   input  logic             i_bit_valid,
   output logic [WIDTH-1:0] o_word,
   output logic             o_word_valid,
   input  logic             i_word_ready,
   output logic [2:0]       o_bit_count,
   output logic             o_overflow
`ifdef VFD_COLLECTOR_PARITY_EN
   ,
   output logic             o_word_parity
`endif
);

   localparam logic [2:0] LAST_IDX = 3'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      FILL
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] asm_q;
   logic [2:0]       count_q;
   logic [WIDTH-1:0] next_word;
   logic             complete;

   // FIFO storage and bookkeeping
   logic [WIDTH-1:0] mem_q [0:1];
   logic             rd_ptr_q, wr_ptr_q;
   logic [1:0]       fill_q;
   logic             overflow_q;
   logic             full, pop, accept;

`ifdef VFD_COLLECTOR_PARITY_EN
   logic             par_q [0:1];
`endif

   // New bit enters at the MSB, so after WIDTH bits the first one sits at bit 0.
   assign next_word = {i_bit, asm_q[WIDTH-1:1]};

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_bit_valid) state_d = FILL;
         end
         FILL: begin
            if (i_bit_valid && (count_q == LAST_IDX)) begin
               state_d  = IDLE;
               complete = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         asm_q   <= '0;
         count_q <= 3'd0;
      end else begin
         state_q <= state_d;
         if (i_bit_valid) begin
            asm_q   <= next_word;
            count_q <= complete ? 3'd0 : count_q + 3'd1;
         end
      end
   end

   assign full   = (fill_q == 2'd2);
   assign pop    = o_word_valid && i_word_ready;
   // A pop on the same edge frees the slot a full FIFO needs.
   assign accept = complete && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         fill_q     <= 2'd0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= next_word;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         fill_q <= fill_q + {1'b0, accept} - {1'b0, pop};
         if (complete && !accept) overflow_q <= 1'b1;
      end
   end

`ifdef VFD_COLLECTOR_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q[0] <= 1'b0;
         par_q[1] <= 1'b0;
      end else if (accept) begin
         par_q[wr_ptr_q] <= ^next_word;
      end
   end

   assign o_word_parity = o_word_valid ? par_q[rd_ptr_q] : 1'b0;
`endif

   assign o_word_valid = (fill_q != 2'd0);
   assign o_word       = o_word_valid ? mem_q[rd_ptr_q] : '0;
   assign o_bit_count  = count_q;
   assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_vfd_word_collector.sv
module tb_vfd_word_collector;

   localparam int WIDTH = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_bit = 1'b0;
   logic             i_bit_valid = 1'b0;
   logic             i_word_ready = 1'b0;
   logic [WIDTH-1:0] o_word;
   logic             o_word_valid;
   logic [2:0]       o_bit_count;
   logic             o_overflow;
`ifdef VFD_COLLECTOR_PARITY_EN
   logic             o_word_parity;
`endif

   int tests = 0;
   int fails = 0;

   vfd_word_collector #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_bit        (i_bit),
      .i_bit_valid  (i_bit_valid),
      .o_word       (o_word),
      .o_word_valid (o_word_valid),
      .i_word_ready (i_word_ready),
      .o_bit_count  (o_bit_count),
      .o_overflow   (o_overflow)
`ifdef VFD_COLLECTOR_PARITY_EN
      ,
      .o_word_parity(o_word_parity)
`endif
   );

   always #5 clk = ~clk;

   // Advance one rising edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      i_bit       = b;
      i_bit_valid = 1'b1;
      tick();
      i_bit_valid = 1'b0;
   endtask

   // Drive a whole word, bit 0 first, on consecutive cycles.
   task automatic send_word(input logic [WIDTH-1:0] w);
      for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_bit_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      tests++; if (o_word_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_word_valid); end
      tests++; if (o_word !== 5'b00000) begin fails++; $display("FAIL reset_word: got %b want 00000", o_word); end
      tests++; if (o_bit_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", o_bit_count); end
      tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
`ifdef VFD_COLLECTOR_PARITY_EN
      tests++; if (o_word_parity !== 1'b0) begin fails++; $display("FAIL reset_parity: got %b want 0", o_word_parity); end
`endif
      tick();
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [4:0] bits;
      bits = 5'b01101; // sent LSB first: 1,0,1,1,0
      i_word_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_bit(bits[i]);
      tests++; if (o_word_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", o_word_valid); end
      tests++; if (o_bit_count !== 3'd4) begin fails++; $display("FAIL basic_count4: got %0d want 4", o_bit_count); end
      send_bit(bits[4]);
      tests++; if (o_word_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", o_word_valid); end
      tests++; if (o_word !== 5'b01101) begin fails++; $display("FAIL basic_word: got %b want 01101", o_word); end
      tests++; if (o_bit_count !== 3'd0) begin fails++; $display("FAIL basic_count0: got %0d want 0", o_bit_count); end
`ifdef VFD_COLLECTOR_PARITY_EN
      tests++; if (o_word_parity !== 1'b1) begin fails++; $display("FAIL basic_parity: got %b want 1", o_word_parity); end
`endif
      tick();
      tests++; if (o_word_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle: got %b want 0", o_word_valid); end
      tests++; if (o_word !== 5'b00000) begin fails++; $display("FAIL basic_word_idle: got %b want 00000", o_word); end
   endtask

   task automatic test_idle_interleave();
      logic [4:0] bits;
      logic [2:0] exp_cnt;
      bits = 5'b01101;
      exp_cnt = 3'd0;
      i_word_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_bit(bits[i]);
         exp_cnt = (i == 4) ? 3'd0 : exp_cnt + 3'd1;
         tests++; if (o_bit_count !== exp_cnt) begin fails++; $display("FAIL idle_count_bit%0d: got %0d want %0d", i, o_bit_count, exp_cnt); end
         if (i == 4) begin
            tests++; if (o_word !== 5'b01101 || o_word_valid !== 1'b1) begin fails++; $display("FAIL idle_word: got %b/%b want 01101/1", o_word, o_word_valid); end
         end
         i_bit = ~bits[i]; // junk on the idle cycle must be ignored
         tick();
         tests++; if (o_bit_count !== exp_cnt) begin fails++; $display("FAIL idle_hold%0d: got %0d want %0d", i, o_bit_count, exp_cnt); end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      i_word_ready = 1'b0;
      send_word(5'b00001);
      send_word(5'b00010);
      tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL ovf_two_words: got %b want 0", o_overflow); end
      send_word(5'b00100);
      tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
      tests++; if (o_word !== 5'b00001 || o_word_valid !== 1'b1) begin fails++; $display("FAIL ovf_head: got %b/%b want 00001/1", o_word, o_word_valid); end
      i_word_ready = 1'b1;
      tick();
      tests++; if (o_word !== 5'b00010 || o_word_valid !== 1'b1) begin fails++; $display("FAIL ovf_second: got %b/%b want 00010/1", o_word, o_word_valid); end
      tick();
      tests++; if (o_word_valid !== 1'b0 || o_word !== 5'b00000) begin fails++; $display("FAIL ovf_drained: got %b/%b want 00000/0", o_word, o_word_valid); end
      tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
   endtask

   task automatic test_full_pop_push();
      logic [4:0] c;
      c = 5'b01001;
      do_reset();
      tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL fpp_ovf_cleared: got %b want 0", o_overflow); end
      i_word_ready = 1'b0;
      send_word(5'b00011);
      send_word(5'b00101);
      for (int i = 0; i < 4; i++) send_bit(c[i]);
      i_word_ready = 1'b1;
      send_bit(c[4]);
      i_word_ready = 1'b0;
      tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL fpp_no_ovf: got %b want 0", o_overflow); end
      tests++; if (o_word !== 5'b00101 || o_word_valid !== 1'b1) begin fails++; $display("FAIL fpp_head: got %b/%b want 00101/1", o_word, o_word_valid); end
      i_word_ready = 1'b1;
      tick();
      tests++; if (o_word !== 5'b01001 || o_word_valid !== 1'b1) begin fails++; $display("FAIL fpp_new: got %b/%b want 01001/1", o_word, o_word_valid); end
      tick();
      tests++; if (o_word_valid !== 1'b0) begin fails++; $display("FAIL fpp_empty: got %b want 0", o_word_valid); end
   endtask

   task automatic test_async_reset();
      logic [4:0] p, e;
      p = 5'b11111;
      e = 5'b11001;
      do_reset();
      i_word_ready = 1'b0;
      send_word(5'b10110);
      for (int i = 0; i < 3; i++) send_bit(p[i]);
      tests++; if (o_bit_count !== 3'd3 || o_word_valid !== 1'b1) begin fails++; $display("FAIL ar_pre: got cnt %0d valid %b want 3/1", o_bit_count, o_word_valid); end
      #3;
      rst = 1'b1; // between clock edges
      #1;
      tests++; if (o_word_valid !== 1'b0 || o_word !== 5'b00000) begin fails++; $display("FAIL ar_word: got %b/%b want 00000/0", o_word, o_word_valid); end
      tests++; if (o_bit_count !== 3'd0 || o_overflow !== 1'b0) begin fails++; $display("FAIL ar_count: got cnt %0d ovf %b want 0/0", o_bit_count, o_overflow); end
      tick();
      rst = 1'b0;
      i_word_ready = 1'b1;
      send_word(e);
      tests++; if (o_word !== 5'b11001 || o_word_valid !== 1'b1) begin fails++; $display("FAIL ar_fresh: got %b/%b want 11001/1", o_word, o_word_valid); end
`ifdef VFD_COLLECTOR_PARITY_EN
      tests++; if (o_word_parity !== 1'b1) begin fails++; $display("FAIL ar_parity: got %b want 1", o_word_parity); end
`endif
      tick();
      tests++; if (o_word_valid !== 1'b0) begin fails++; $display("FAIL ar_popped: got %b want 0", o_word_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_idle_interleave();
      test_overflow();
      test_full_pop_push();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
